// File: rtl/pixel_pack_4x_if.sv
// Pixel-in / packed-word-out bundle for pixel_pack_4x.
// slave is the packer's view; master is the view of whatever drives the pixels.
interface pixel_pack_4x_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int CW          = 9
);
    logic [PIXEL_WIDTH-1:0]   di_i;
    logic                     de_i;
    logic                     hs_i;
    logic                     vs_i;
    logic [4*PIXEL_WIDTH-1:0] do_o;
    logic                     dv_o;
    logic [3:0]               be_o;
    logic                     sol_o;
    logic                     eol_o;
    logic                     sof_o;
    logic [CW-1:0]            line_words_o;
    logic                     ovf_o;

    modport slave (
        input  di_i, de_i, hs_i, vs_i,
        output do_o, dv_o, be_o, sol_o, eol_o, sof_o, line_words_o, ovf_o
    );

    modport master (
        output di_i, de_i, hs_i, vs_i,
        input  do_o, dv_o, be_o, sol_o, eol_o, sof_o, line_words_o, ovf_o
    );
endinterface

// File: rtl/pixel_pack_4x.sv
// Packs four consecutive pixels into one word, flushing partial words at line/frame end.
// A completed word is held back until the next pixel or the line end tells us whether it is the last one.
module pixel_pack_4x #(
    parameter  int PIXEL_WIDTH   = 8,
    parameter  int LINE_SIZE_MAX = 1024,
    localparam int CW            = $clog2(LINE_SIZE_MAX/4 + 1)
) (
    input  logic             clk,
    input  logic             rst,
    pixel_pack_4x_if.slave   bus
);
    localparam int MAXW = LINE_SIZE_MAX / 4;

    logic                         r_hs_q;
    logic                         r_vs_q;
    logic [1:0]                   r_cnt;
    logic [3:0][PIXEL_WIDTH-1:0]  r_lanes;
    logic                         r_pend;
    logic [3:0][PIXEL_WIDTH-1:0]  r_pend_word;
    logic                         r_defer_vld;
    logic [3:0][PIXEL_WIDTH-1:0]  r_defer_word;
    logic [3:0]                   r_defer_be;
    logic                         r_sol_arm;
    logic                         r_sof_arm;
    logic [CW-1:0]                r_wcnt;
    logic [4*PIXEL_WIDTH-1:0]     r_do;
    logic                         r_dv;
    logic [3:0]                   r_be;
    logic                         r_sol;
    logic                         r_eol;
    logic                         r_sof;
    logic [CW-1:0]                r_line_words;
    logic                         r_ovf;

    logic                         w_de;
    logic                         w_le;
    logic                         w_fe;
    logic                         w_flush;
    logic                         w_wrap;
    logic [1:0]                   w_cnt_de;
    logic [3:0][PIXEL_WIDTH-1:0]  w_asm;
    logic                         w_pend_de;
    logic [3:0][PIXEL_WIDTH-1:0]  w_pend_word_de;
    logic                         w_de_emit;
    logic                         w_fl_pend;
    logic                         w_fl_part;
    logic                         w_fl_emit;
    logic [3:0][PIXEL_WIDTH-1:0]  w_fl_word;
    logic [3:0]                   w_part_be;
    logic [3:0]                   w_fl_be;
    logic                         w_defer_set;

    logic                         w_emit;
    logic [3:0][PIXEL_WIDTH-1:0]  w_emit_word;
    logic [3:0]                   w_emit_be;
    logic                         w_emit_eol;
    logic                         w_emit_first;
    logic                         w_sat;
    logic [CW-1:0]                w_wcnt_inc;
    logic                         w_sol_arm_next;
    logic                         w_sof_arm_next;

    // Pixels outside the active frame are dropped entirely.
    assign w_de     = bus.de_i & bus.vs_i;
    assign w_le     = bus.hs_i & ~r_hs_q;
    assign w_fe     = ~bus.vs_i & r_vs_q;
    assign w_flush  = w_le | w_fe;
    assign w_wrap   = w_de && (r_cnt == 2'd3);
    assign w_cnt_de = w_de ? r_cnt + 2'd1 : r_cnt;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_asm[gi]     = (w_de && (r_cnt == 2'(gi))) ? bus.di_i : r_lanes[gi];
            assign w_part_be[gi] = (w_cnt_de > 2'(gi));
        end
    endgenerate

    // A pending word always sits with cnt=0, so a pixel either releases it or the line ends.
    assign w_de_emit      = w_de & r_pend;
    assign w_pend_de      = w_de ? w_wrap : r_pend;
    assign w_pend_word_de = w_wrap ? w_asm : r_pend_word;

    assign w_fl_pend = w_flush & w_pend_de & (w_cnt_de == 2'd0);
    assign w_fl_part = w_flush & (w_cnt_de != 2'd0);
    assign w_fl_emit = w_fl_pend | w_fl_part;
    assign w_fl_word = w_fl_pend ? w_pend_word_de : w_asm;
    assign w_fl_be   = w_fl_pend ? 4'b1111 : w_part_be;

    // A pixel that releases the pending word while the line ends leaves a second word;
    // it goes out on the following cycle, which is guaranteed idle.
    assign w_defer_set = w_fl_emit & w_de_emit;

    always_comb begin
        w_emit       = 1'b0;
        w_emit_word  = r_pend_word;
        w_emit_be    = 4'b1111;
        w_emit_eol   = 1'b0;
        w_emit_first = 1'b0;
        if (r_defer_vld) begin
            w_emit      = 1'b1;
            w_emit_word = r_defer_word;
            w_emit_be   = r_defer_be;
            w_emit_eol  = 1'b1;
        end else if (w_de_emit) begin
            w_emit       = 1'b1;
            w_emit_first = 1'b1;
        end else if (w_fl_emit) begin
            w_emit       = 1'b1;
            w_emit_word  = w_fl_word;
            w_emit_be    = w_fl_be;
            w_emit_eol   = 1'b1;
            w_emit_first = 1'b1;
        end
    end

    assign w_sat      = (r_wcnt == CW'(MAXW));
    assign w_wcnt_inc = w_sat ? r_wcnt : r_wcnt + CW'(1);

    always_comb begin
        w_sol_arm_next = r_sol_arm;
        w_sof_arm_next = r_sof_arm;
        if (w_emit && w_emit_first) begin
            w_sol_arm_next = 1'b0;
            w_sof_arm_next = 1'b0;
        end
        if (w_flush) w_sol_arm_next = 1'b1;
        if (w_fe)    w_sof_arm_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hs_q       <= 1'b1;
            r_vs_q       <= 1'b0;
            r_cnt        <= '0;
            r_lanes      <= '0;
            r_pend       <= 1'b0;
            r_pend_word  <= '0;
            r_defer_vld  <= 1'b0;
            r_defer_word <= '0;
            r_defer_be   <= '0;
            r_sol_arm    <= 1'b1;
            r_sof_arm    <= 1'b1;
            r_wcnt       <= '0;
            r_do         <= '0;
            r_dv         <= 1'b0;
            r_be         <= '0;
            r_sol        <= 1'b0;
            r_eol        <= 1'b0;
            r_sof        <= 1'b0;
            r_line_words <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_hs_q      <= bus.hs_i;
            r_vs_q      <= bus.vs_i;
            r_cnt       <= w_flush ? 2'd0 : w_cnt_de;
            r_lanes     <= (w_flush | w_wrap) ? '0 : w_asm;
            r_pend      <= w_flush ? 1'b0 : w_pend_de;
            r_pend_word <= w_pend_word_de;
            r_defer_vld <= w_defer_set;
            if (w_defer_set) begin
                r_defer_word <= w_fl_word;
                r_defer_be   <= w_fl_be;
            end
            r_sol_arm <= w_sol_arm_next;
            r_sof_arm <= w_sof_arm_next;

            r_dv  <= w_emit;
            r_eol <= w_emit & w_emit_eol;
            r_sol <= w_emit & w_emit_first & r_sol_arm;
            r_sof <= w_emit & w_emit_first & r_sof_arm;
            if (w_emit) begin
                r_do <= w_emit_word;
                r_be <= w_emit_be;
                if (w_sat) r_ovf <= 1'b1;
                if (w_emit_eol) begin
                    r_line_words <= w_wcnt_inc;
                    r_wcnt       <= '0;
                end else begin
                    r_wcnt <= w_wcnt_inc;
                end
            end
        end
    end

    assign bus.do_o         = r_do;
    assign bus.dv_o         = r_dv;
    assign bus.be_o         = r_be;
    assign bus.sol_o        = r_sol;
    assign bus.eol_o        = r_eol;
    assign bus.sof_o        = r_sof;
    assign bus.line_words_o = r_line_words;
    assign bus.ovf_o        = r_ovf;
endmodule

// File: tb/tb_pixel_pack_4x.sv
// Directed bench for pixel_pack_4x with LINE_SIZE_MAX=16 so overflow is reachable quickly.
module tb_pixel_pack_4x;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    pixel_pack_4x_if #(.PIXEL_WIDTH(8), .CW(3)) bus ();

    pixel_pack_4x #(.PIXEL_WIDTH(8), .LINE_SIZE_MAX(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (bus.dv_o)
            $display("word do=%h be=%b sol=%0d eol=%0d sof=%0d lw=%0d ovf=%0d",
                     bus.do_o, bus.be_o, bus.sol_o, bus.eol_o, bus.sof_o,
                     bus.line_words_o, bus.ovf_o);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic de, input logic [7:0] di, input logic hs, input logic vs);
        bus.de_i = de;
        bus.di_i = di;
        bus.hs_i = hs;
        bus.vs_i = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] w, input logic [3:0] be,
                            input logic sol, input logic eol, input logic sof);
        check(tag, {24'd0, bus.dv_o, bus.be_o, bus.sol_o, bus.eol_o, bus.sof_o, bus.do_o},
                   {24'd0, 1'b1, be, sol, eol, sof, w});
    endtask

    task automatic chk_idle(input string tag);
        check(tag, 64'(bus.dv_o), 64'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;
        bus.de_i = 1'b0;
        bus.di_i = 8'h00;
        bus.hs_i = 1'b1;
        bus.vs_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {bus.dv_o, bus.be_o, bus.sol_o, bus.eol_o, bus.sof_o,
                                bus.do_o, bus.line_words_o, bus.ovf_o}, 64'd0);
        rst = 1'b1;

        // Line 1: eight sparse pixels, then line end.
        cyc(0, 8'h00, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 8'(i), 0, 1);
            if (i == 5) chk_word("t1_w0", 32'h04030201, 4'hF, 1, 0, 1);
            else if (i == 4) chk_idle("t1_hold_pend");
            cyc(0, 8'h00, 0, 1);
        end
        cyc(0, 8'h00, 1, 1);
        chk_word("t1_w1", 32'h08070605, 4'hF, 0, 1, 0);
        check("t1_lw", 64'(bus.line_words_o), 64'd2);
        cyc(0, 8'h00, 1, 1);
        chk_idle("t1_no_le_hs_high");
        check("t1_do_held", 64'(bus.do_o), 64'h08070605);

        // Line 2: six pixels -> full word plus two-lane partial.
        cyc(0, 8'h00, 0, 1);
        for (int i = 1; i <= 6; i++) begin
            cyc(1, 8'h10 + 8'(i), 0, 1);
            if (i == 5) chk_word("t2_w0", 32'h14131211, 4'hF, 1, 0, 0);
        end
        cyc(0, 8'h00, 1, 1);
        chk_word("t2_w1", 32'h00001615, 4'b0011, 0, 1, 0);
        check("t2_lw", 64'(bus.line_words_o), 64'd2);

        // Line 3: fourth pixel coincides with line end.
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'h21, 0, 1);
        cyc(1, 8'h22, 0, 1);
        cyc(1, 8'h23, 0, 1);
        cyc(1, 8'h24, 1, 1);
        chk_word("t3_w0", 32'h24232221, 4'hF, 1, 1, 0);
        check("t3_lw", 64'(bus.line_words_o), 64'd1);

        // Line 4: empty line.
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 1, 1);
        chk_idle("t4_empty");
        check("t4_lw_kept", 64'(bus.line_words_o), 64'd1);

        // Line 5: fifth pixel lands on line end -> two words on consecutive cycles.
        cyc(0, 8'h00, 0, 1);
        for (int i = 1; i <= 4; i++) cyc(1, 8'h30 + 8'(i), 0, 1);
        cyc(1, 8'h35, 1, 1);
        chk_word("t5_w0", 32'h34333231, 4'hF, 1, 0, 0);
        cyc(0, 8'h00, 1, 1);
        chk_word("t5_w1", 32'h00000035, 4'b0001, 0, 1, 0);
        check("t5_lw", 64'(bus.line_words_o), 64'd2);

        // Frame end after three pixels, with a stray strobe outside the frame.
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'h41, 0, 1);
        cyc(1, 8'h42, 0, 1);
        cyc(1, 8'h43, 0, 1);
        cyc(0, 8'h00, 0, 0);
        chk_word("t6_fe", 32'h00434241, 4'b0111, 1, 1, 0);
        cyc(1, 8'hEE, 0, 0);
        chk_idle("t6_outside_frame");
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 8'h50 + 8'(i), 0, 1);
            if (i == 5) chk_word("t6_new_frame", 32'h54535251, 4'hF, 1, 0, 1);
        end
        cyc(0, 8'h00, 1, 1);
        chk_word("t6_tail", 32'h00000055, 4'b0001, 0, 1, 0);

        // Overflow: 20 pixels against a four-word line limit.
        cyc(0, 8'h00, 0, 1);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 8'h60 + 8'(i), 0, 1);
            if (i == 4)  chk_word("t7_w0", 32'h63626160, 4'hF, 1, 0, 0);
            if (i == 16) check("t7_no_ovf_yet", 64'(bus.ovf_o), 64'd0);
        end
        cyc(0, 8'h00, 1, 1);
        chk_word("t7_last", 32'h73727170, 4'hF, 0, 1, 0);
        check("t7_ovf", 64'(bus.ovf_o), 64'd1);
        check("t7_lw_sat", 64'(bus.line_words_o), 64'd4);
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'hA1, 0, 1);
        cyc(1, 8'hA2, 0, 1);
        cyc(0, 8'h00, 1, 1);
        chk_word("t7_next_line", 32'h0000A2A1, 4'b0011, 1, 1, 0);
        check("t7_ovf_sticky", 64'(bus.ovf_o), 64'd1);
        check("t7_lw_next", 64'(bus.line_words_o), 64'd1);

        // Reset mid-line discards the partial word.
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'h81, 0, 1);
        cyc(1, 8'h82, 0, 1);
        cyc(1, 8'h83, 0, 1);
        #1;
        rst = 1'b0;
        #1;
        check("t8_async_reset", {bus.dv_o, bus.be_o, bus.sol_o, bus.eol_o, bus.sof_o,
                                 bus.do_o, bus.line_words_o, bus.ovf_o}, 64'd0);
        bus.de_i = 1'b0;
        bus.hs_i = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(0, 8'h00, 1, 1);
        chk_idle("t8_no_flush");
        cyc(0, 8'h00, 0, 1);
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 8'h90 + 8'(i), 0, 1);
            if (i == 5) chk_word("t8_first", 32'h94939291, 4'hF, 1, 0, 1);
        end
        cyc(0, 8'h00, 1, 1);
        chk_word("t8_tail", 32'h00000095, 4'b0001, 0, 1, 0);
        check("t8_lw", 64'(bus.line_words_o), 64'd2);
        check("t8_ovf_cleared", 64'(bus.ovf_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pixel_pack_4x.md
PIXEL_PACK_4X -- requirements
Module: pixel_pack_4x

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8: bits per input pixel.
REQ-002 SHALL have parameter LINE_SIZE_MAX, default 1024: maximum output pixels per line; sets the word-counter width to $clog2(LINE_SIZE_MAX/4+1).
REQ-003 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port di_i  input  PIXEL_WIDTH: pixel from the upstream binning stage, valid when de_i=1.
REQ-006 SHALL have port de_i  input  1: pixel strobe; may be sparse, with any gap length.
REQ-007 SHALL have port hs_i  input  1: low during active line; a rising edge marks line end.
REQ-008 SHALL have port vs_i  input  1: high during active frame.
REQ-009 SHALL have port do_o  output  4*PIXEL_WIDTH: packed word; lane k = bits [k*PIXEL_WIDTH +: PIXEL_WIDTH]; lane 0 holds the earliest pixel.
REQ-010 SHALL have port dv_o  output  1: one-cycle word strobe; there is no backpressure.
REQ-011 SHALL have port be_o  output  4: lane-valid mask for do_o.
REQ-012 SHALL have port sol_o / eol_o / sof_o  output  1 each: first word of line / last word of line / first word of frame; each is qualified by dv_o.
REQ-013 SHALL have port line_words_o  output  counter width: word count of the last completed line; updates in the cycle eol_o is asserted.
REQ-014 SHALL have port ovf_o  output  1: sticky line-length overflow flag.

Function
REQ-015 SHALL detect line end (LE) when hs_i=1 and hs_q=0; hs_q is hs_i registered, with reset value 1.
REQ-016 SHALL detect frame end (FE) when vs_i=0 and vs_q=1; FE SHALL be treated as LE for flushing.
REQ-017 SHALL, on each de_i=1, write di_i into lane cnt and increment the 2-bit lane counter cnt, wrapping 3->0.
REQ-018 SHALL, when cnt wraps, move the assembled word into a pending register and set pend=1 without emitting it.
REQ-019 SHALL emit the pending word (dv_o=1, be_o=4'b1111, eol_o=0) one cycle after the next de_i of the same line.
REQ-020 SHALL, on LE/FE with pend=1 and cnt=0, emit the pending word one cycle later with eol_o=1 and be_o=4'b1111.
REQ-021 SHALL, on LE/FE with cnt!=0, emit the partial word one cycle later with eol_o=1, be_o set for lanes 0..cnt-1 and unused lanes zero.
REQ-022 SHALL, on LE/FE with pend=0 and cnt=0 (empty line), emit nothing and leave line_words_o unchanged.
REQ-023 SHALL treat a de_i in the same cycle as LE as belonging to the ending line; that pixel is included before the flush.
REQ-024 SHALL clear cnt and pend after every flush; the next line starts at lane 0.
REQ-025 SHALL assert sol_o on the first emitted word after reset or after each flush.
REQ-026 SHALL assert sof_o on the first emitted word after reset or after each FE; sof_o implies sol_o.
REQ-027 SHALL ignore de_i while vs_i=0: no lane write, no counting.
REQ-028 SHALL have a word counter that increments per emitted word, loads line_words_o on eol_o, and clears after each flush.
REQ-029 SHALL, if the word counter would exceed LINE_SIZE_MAX/4, saturate the counter and set ovf_o, which clears only on reset; packing and output continue.
REQ-030 SHALL register all outputs, with a fixed latency of 1 clk from the triggering event (de_i or LE/FE) to dv_o.
REQ-031 SHALL hold do_o at its last emitted value while dv_o=0.

Reset
REQ-032 SHALL, while rst=0, force do_o=0, dv_o=0, be_o=0, sol_o=0, eol_o=0, sof_o=0, line_words_o=0, ovf_o=0, cnt=0, pend=0, hs_q=1 and vs_q=0, and arm both sol and sof.
REQ-033 SHALL, when reset is asserted mid-line, discard any partial or pending data with no flush output; output resumes with sof_o=1 on the first word after release.

Verification
REQ-034 SHALL cover: 8 pixels 0x01..0x08, DE_SPARSE=1 gaps, then LE -> two words 0x04030201 (sol_o=1, sof_o=1) and 0x08070605 (eol_o=1), be_o=4'hF, line_words_o=2.
REQ-035 SHALL cover: 6 pixels 0x11..0x16 then LE -> 0x14131211, then 0x00001615 with be_o=4'b0011 and eol_o=1.
REQ-036 SHALL cover: 4th pixel de_i in the same cycle as LE -> a single word with eol_o=1 and be_o=4'hF, one cycle later.
REQ-037 SHALL cover: a line with no de_i between two LEs -> no dv_o and line_words_o unchanged.
REQ-038 SHALL cover: 3 pixels then vs_i falls -> partial word with eol_o=1 and be_o=4'b0111; the first word of the next frame has sof_o=1.
REQ-039 SHALL cover: LINE_SIZE_MAX=16 with 20 pixels in one line -> ovf_o=1, remaining until reset; rst pulse low mid-line -> all outputs 0 and no flush word.
